// File: rtl/ppi_bus_sequencer.sv
// Host-side bus master for an 8255-style PPI: sequences one request into a
// timed CS/A/RD/WR strobe cycle and holds the PPI in reset after power-up.
module ppi_bus_sequencer #(
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1,
   parameter int unsigned RECOV_CYC = 1,
   parameter int unsigned RST_CYC   = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rnw,
   input  logic [1:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       PPI_RESET,
   output logic       CS,
   output logic       RD,
   output logic       WR,
   output logic [1:0] A,
   output logic [7:0] D_out,
   output logic       D_oe,
   input  logic [7:0] D_in
);

   localparam logic [2:0] StInit   = 3'd0;
   localparam logic [2:0] StIdle   = 3'd1;
   localparam logic [2:0] StSetup  = 3'd2;
   localparam logic [2:0] StStrobe = 3'd3;
   localparam logic [2:0] StHold   = 3'd4;
   localparam logic [2:0] StRecov  = 3'd5;

   // Terminal count per phase; a zero parameter still yields a one-cycle phase.
   localparam logic [3:0] SetupLim = (SETUP_CYC == 0) ? 4'd0 : 4'(SETUP_CYC - 1);
   localparam logic [3:0] PulseLim = (PULSE_CYC == 0) ? 4'd0 : 4'(PULSE_CYC - 1);
   localparam logic [3:0] HoldLim  = (HOLD_CYC == 0)  ? 4'd0 : 4'(HOLD_CYC - 1);
   localparam logic [3:0] RecovLim = (RECOV_CYC == 0) ? 4'd0 : 4'(RECOV_CYC - 1);
   localparam logic [3:0] RstLim   = (RST_CYC == 0)   ? 4'd0 : 4'(RST_CYC - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rnw_q, rnw_d;
   logic       accept;
   logic       active_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 4'd1;
      accept  = (state_q == StIdle) && req_valid;
      case (state_q)
         StInit:   if (cnt_q == RstLim)   state_d = StIdle;
         StIdle:   if (req_valid)         state_d = StSetup;
         StSetup:  if (cnt_q == SetupLim) state_d = StStrobe;
         StStrobe: if (cnt_q == PulseLim) state_d = StHold;
         StHold:   if (cnt_q == HoldLim)  state_d = StRecov;
         StRecov:  if (cnt_q == RecovLim) state_d = StIdle;
         default:  state_d = StInit;
      endcase
      if (state_d != state_q) cnt_d = 4'd0;
      rnw_d    = accept ? req_rnw : rnw_q;
      active_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
   end

   // Outputs are decoded from the next state so every pin comes straight off a flop.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= StInit;
         cnt_q     <= 4'd0;
         rnw_q     <= 1'b0;
         PPI_RESET <= 1'b1;
         req_ready <= 1'b0;
         CS        <= 1'b1;
         RD        <= 1'b1;
         WR        <= 1'b1;
         A         <= 2'd0;
         D_out     <= 8'd0;
         D_oe      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rnw_q     <= rnw_d;
         PPI_RESET <= (state_d == StInit);
         req_ready <= (state_d == StIdle);
         CS        <= !active_d;
         RD        <= !((state_d == StStrobe) && rnw_d);
         WR        <= !((state_d == StStrobe) && !rnw_d);
         D_oe      <= active_d && !rnw_d;
         rsp_valid <= (state_d == StRecov) && (state_q != StRecov);
         if (accept) begin
            A <= req_addr;
            if (!req_rnw) D_out <= req_wdata;
         end
         if ((state_q == StStrobe) && (state_d != StStrobe) && rnw_q) rsp_rdata <= D_in;
      end
   end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer: default-timing instance plus an
// all-zero-parameter instance, table-driven transactions and corner sequences.
module tb_ppi_bus_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       req_valid, z_valid;
   logic       req_rnw;
   logic [1:0] req_addr;
   logic [7:0] req_wdata, d_in;

   logic       d_ready, d_rsp, d_pr, d_cs, d_rd, d_wr, d_oe;
   logic [7:0] d_rdata, d_dout;
   logic [1:0] d_a;
   logic       z_ready, z_rsp, z_pr, z_cs, z_rd, z_wr, z_oe;
   logic [7:0] z_rdata, z_dout;
   logic [1:0] z_a;

   ppi_bus_sequencer dut (
      .CLK(clk), .RESET_N(rst_n), .req_valid(req_valid), .req_ready(d_ready),
      .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(d_rsp), .rsp_rdata(d_rdata), .PPI_RESET(d_pr), .CS(d_cs), .RD(d_rd),
      .WR(d_wr), .A(d_a), .D_out(d_dout), .D_oe(d_oe), .D_in(d_in)
   );

   ppi_bus_sequencer #(
      .SETUP_CYC(0), .PULSE_CYC(0), .HOLD_CYC(0), .RECOV_CYC(0), .RST_CYC(0)
   ) dut_z (
      .CLK(clk), .RESET_N(rst_n), .req_valid(z_valid), .req_ready(z_ready),
      .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(z_rsp), .rsp_rdata(z_rdata), .PPI_RESET(z_pr), .CS(z_cs), .RD(z_rd),
      .WR(z_wr), .A(z_a), .D_out(z_dout), .D_oe(z_oe), .D_in(d_in)
   );

   logic       sel;
   logic       m_ready, m_rsp, m_cs, m_rd, m_wr, m_oe;
   logic [7:0] m_rdata, m_dout;
   logic [1:0] m_a;
   assign m_ready = sel ? z_ready : d_ready;
   assign m_rsp   = sel ? z_rsp   : d_rsp;
   assign m_cs    = sel ? z_cs    : d_cs;
   assign m_rd    = sel ? z_rd    : d_rd;
   assign m_wr    = sel ? z_wr    : d_wr;
   assign m_oe    = sel ? z_oe    : d_oe;
   assign m_rdata = sel ? z_rdata : d_rdata;
   assign m_dout  = sel ? z_dout  : d_dout;
   assign m_a     = sel ? z_a     : d_a;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Bus invariants on both instances, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("inv_rdwr_d", int'(d_rd | d_wr), 1);
         chk("inv_strobe_cs_d", int'((!d_rd || !d_wr) && d_cs), 0);
         chk("inv_oe_cs_d", int'(d_oe && d_cs), 0);
         chk("inv_rdwr_z", int'(z_rd | z_wr), 1);
         chk("inv_strobe_cs_z", int'((!z_rd || !z_wr) && z_cs), 0);
         chk("inv_oe_cs_z", int'(z_oe && z_cs), 0);
      end
   end

   typedef struct {
      bit       sel;
      bit       rnw;
      bit [1:0] addr;
      bit [7:0] wdata;
      bit [7:0] din;
      bit [7:0] exp_rdata;
      int       exp_cs;
      int       exp_strobe;
      int       exp_first;
      int       exp_rsp;
      int       exp_busy;
   } vec_t;

   typedef struct {
      int       cs;
      int       strobe;
      int       other;
      int       first;
      int       nrsp;
      int       rsp_idx;
      int       busy;
      int       bad;
      bit [7:0] rdata;
   } res_t;

   task automatic wait_ready(input string name);
      int ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (m_ready) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (ok == 0) chk({name, "_ready_timeout"}, 0, 1);
   endtask

   task automatic run_txn(input vec_t v, output res_t r);
      logic st, ot;
      sel = v.sel;
      #0;
      wait_ready("txn");
      r = '{cs: 0, strobe: 0, other: 0, first: -1, nrsp: 0, rsp_idx: -1, busy: -1, bad: 0,
            rdata: 8'h00};
      req_rnw = v.rnw; req_addr = v.addr; req_wdata = v.wdata; d_in = v.din;
      if (v.sel) z_valid = 1'b1; else req_valid = 1'b1;
      @(posedge clk); #1;
      z_valid = 1'b0; req_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (!m_cs) begin
            r.cs++;
            if (m_a != v.addr || m_oe != !v.rnw || (!v.rnw && m_dout != v.wdata)) r.bad++;
         end
         st = v.rnw ? m_rd : m_wr;
         ot = v.rnw ? m_wr : m_rd;
         if (!st) begin
            r.strobe++;
            if (r.first < 0) r.first = k;
         end
         if (!ot) r.other++;
         if (m_rsp) begin
            r.nrsp++;
            r.rsp_idx = k;
            r.rdata = m_rdata;
         end
         if (m_ready) begin
            r.busy = k - 1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_release(input string name);
      int highs = 0, busbad = 0, rsp = 0, done = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (d_pr) highs++;
         else begin
            done = 1;
            break;
         end
         if (!d_cs || !d_rd || !d_wr) busbad++;
         if (d_rsp) rsp++;
         @(posedge clk); #1;
      end
      chk({name, "_ppi_reset_cycles"}, highs, 4);
      chk({name, "_ppi_reset_fell"}, done, 1);
      chk({name, "_ready_with_fall"}, int'(d_ready), 1);
      chk({name, "_bus_idle"}, busbad, 0);
      chk({name, "_no_rsp"}, rsp, 0);
   endtask

   vec_t vecs[7];
   res_t r;

   initial begin
      int falls, gap, gap2, rsp, done, nacc;
      logic prev_cs;
      rst_n = 1'b1; req_valid = 1'b0; z_valid = 1'b0; sel = 1'b0;
      req_rnw = 1'b0; req_addr = 2'd0; req_wdata = 8'h00; d_in = 8'h00;

      //          sel rnw addr wdata  din    rdata  cs str fst rsp busy
      vecs[0] = '{1'b0, 1'b0, 2'd3, 8'h80, 8'h00, 8'h00, 4, 2, 2, 5, 5};
      vecs[1] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'hF0, 8'hF0, 4, 2, 2, 5, 5};
      vecs[2] = '{1'b0, 1'b0, 2'd1, 8'h3C, 8'h11, 8'hF0, 4, 2, 2, 5, 5};
      vecs[3] = '{1'b0, 1'b1, 2'd2, 8'hFF, 8'h5A, 8'h5A, 4, 2, 2, 5, 5};
      vecs[4] = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 8'h5A, 4, 2, 2, 5, 5};
      vecs[5] = '{1'b1, 1'b1, 2'd1, 8'h00, 8'h33, 8'h33, 3, 1, 2, 4, 4};
      vecs[6] = '{1'b1, 1'b0, 2'd2, 8'h0F, 8'hC3, 8'h33, 3, 1, 2, 4, 4};

      #1 rst_n = 1'b0;
      #2;
      chk("rst_ppi_reset", int'(d_pr), 1);
      chk("rst_cs_rd_wr", int'({d_cs, d_rd, d_wr}), 7);
      chk("rst_a", int'(d_a), 0);
      chk("rst_dout", int'(d_dout), 0);
      chk("rst_oe", int'(d_oe), 0);
      chk("rst_ready", int'(d_ready), 0);
      chk("rst_rsp", int'(d_rsp), 0);
      chk("rst_rdata", int'(d_rdata), 0);
      #20;
      reset_release("init");

      foreach (vecs[i]) begin
         run_txn(vecs[i], r);
         chk($sformatf("v%0d_cs_cycles", i), r.cs, vecs[i].exp_cs);
         chk($sformatf("v%0d_strobe_cycles", i), r.strobe, vecs[i].exp_strobe);
         chk($sformatf("v%0d_strobe_first", i), r.first, vecs[i].exp_first);
         chk($sformatf("v%0d_other_strobe", i), r.other, 0);
         chk($sformatf("v%0d_bus_fields", i), r.bad, 0);
         chk($sformatf("v%0d_rsp_count", i), r.nrsp, 1);
         chk($sformatf("v%0d_rsp_cycle", i), r.rsp_idx, vecs[i].exp_rsp);
         chk($sformatf("v%0d_busy_cycles", i), r.busy, vecs[i].exp_busy);
         chk($sformatf("v%0d_rdata", i), int'(r.rdata), int'(vecs[i].exp_rdata));
      end

      // Two queued requests with req_valid held high throughout.
      sel = 1'b0;
      #0;
      wait_ready("queue");
      req_rnw = 1'b0; req_addr = 2'd1; req_wdata = 8'h3C; d_in = 8'h77; req_valid = 1'b1;
      @(posedge clk); #1;
      req_rnw = 1'b1; req_addr = 2'd2;
      nacc = 1; falls = 0; gap = 0; gap2 = -1; rsp = 0; done = 0; prev_cs = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (prev_cs && !d_cs) begin
            falls++;
            if (falls == 2) gap2 = gap;
         end
         if (d_cs) gap++;
         if (d_rsp) rsp++;
         prev_cs = d_cs;
         if (d_ready && nacc == 2) begin
            done = 1;
            break;
         end
         @(posedge clk); #1;
         if (nacc == 1 && req_valid && !d_cs && falls == 1 && gap > 0) begin
            req_valid = 1'b0;
            nacc = 2;
         end
      end
      chk("queue_done", done, 1);
      chk("queue_cs_falls", falls, 2);
      chk("queue_cs_gap_ge1", int'(gap2 >= 1), 1);
      chk("queue_rsp_pulses", rsp, 2);
      chk("queue_rdata", int'(d_rdata), 8'h77);

      // Reset asserted while a write strobe is active.
      wait_ready("midrst");
      req_rnw = 1'b0; req_addr = 2'd2; req_wdata = 8'h55; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      done = 0;
      for (int k = 0; k < 10; k++) begin
         if (!d_wr) begin
            done = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("midrst_strobe_seen", done, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_cs", int'(d_cs), 1);
      chk("midrst_wr", int'(d_wr), 1);
      chk("midrst_oe", int'(d_oe), 0);
      chk("midrst_ppi_reset", int'(d_pr), 1);
      chk("midrst_rsp", int'(d_rsp), 0);
      #15;
      reset_release("midrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule
